read_channel_scheduler: RTL and testbench

Sequences the shared read path of the two-master AXI interconnect onto its single slave port. It picks the owning master by QoS, with optional aging. It gates and steers the AR channel and routes the R channel back to the owner. It tracks outstanding bursts, so one owner may pipeline up to MAX_OUTSTANDING reads before the path is released and re-arbitrated.

---
 rtl/read_channel_scheduler.sv | 119 +++++++++++
 tb/tb_read_channel_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_channel_scheduler.sv
// Shared read-path scheduler for a two-master AXI interconnect: QoS arbitration, AR gating,
// R steering and outstanding-burst tracking. Define READ_SCHED_AGING_EN to add starvation aging.
module read_channel_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int AGE_LIMIT       = 15,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             S00_AXI_arvalid,
  input  logic [3:0]       S00_AXI_arqos,
  input  logic             S01_AXI_arvalid,
  input  logic [3:0]       S01_AXI_arqos,
  input  logic             M_AXI_arready,
  input  logic             M_AXI_rvalid,
  input  logic             M_AXI_rready,
  input  logic             M_AXI_rlast,
  output logic             ar_enable,
  output logic             ar_select,
  output logic             r_select,
  output logic             busy,
  output logic [CNT_W-1:0] outstanding
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  state_e           state_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       arvalid;
  logic             owner_valid, ar_hs, r_done, r_dec;
  logic             qos_winner, winner, reentry_ok;

  assign arvalid     = {S01_AXI_arvalid, S00_AXI_arvalid};
  assign owner_valid = arvalid[owner_q];
  assign ar_hs       = (state_q == ADDR) && owner_valid && M_AXI_arready;
  assign r_done      = M_AXI_rvalid && M_AXI_rready && M_AXI_rlast;
  // A last beat with nothing outstanding (e.g. a burst cut off by reset) is dropped.
  assign r_dec       = r_done && (cnt_q != '0);
  assign qos_winner  = S01_AXI_arvalid && (!S00_AXI_arvalid || (S01_AXI_arqos > S00_AXI_arqos));

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (ar_hs && !r_dec)      cnt_d = cnt_q + CNT_W'(1);
    else if (r_dec && !ar_hs) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      cnt_q <= cnt_d;
      case (state_q)
        IDLE: if (|arvalid) begin
          owner_q <= winner;
          state_q <= ADDR;
        end
        // A dropped arvalid in ADDR can only follow a handshake, so it ends the AR run.
        ADDR: if (ar_hs) begin
          if (cnt_d == CNT_MAX) state_q <= DATA;
        end else if (!owner_valid) begin
          state_q <= DATA;
        end
        DATA: if (cnt_d == '0) begin
          state_q <= IDLE;
        end else if (owner_valid && (cnt_d < CNT_MAX) && reentry_ok) begin
          state_q <= ADDR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef READ_SCHED_AGING_EN
  localparam logic [7:0] AGE_MAX = 8'(AGE_LIMIT);

  logic [1:0][7:0] age_q;
  logic [1:0]      aged, aged_valid;

  assign aged       = {age_q[1] == AGE_MAX, age_q[0] == AGE_MAX};
  assign aged_valid = aged & arvalid;
  // A starving master loses the path only by being barred from re-entry, never mid-run.
  assign reentry_ok = !aged[~owner_q];

  always_comb begin
    winner = qos_winner;
    if (&aged_valid)        winner = ~owner_q;
    else if (aged_valid[1]) winner = 1'b1;
    else if (aged_valid[0]) winner = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ar_hs && (owner_q == 1'(i)))   age_q[i] <= '0;
        else if (arvalid[i] && !aged[i])   age_q[i] <= age_q[i] + 8'd1;
      end
    end
  end
`else
  assign winner     = qos_winner;
  assign reentry_ok = 1'b1;
`endif

  assign ar_enable   = (state_q == ADDR);
  assign busy        = (state_q != IDLE);
  assign ar_select   = owner_q;
  assign r_select    = owner_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_read_channel_scheduler.sv
// Self-checking bench for read_channel_scheduler: directed scenarios plus a randomized run
// scored against a handshake-counting reference model.
module tb_read_channel_scheduler;

  localparam int MAX_OUT = 4;
  localparam int AGE_LIM = 4;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic          ACLK, ARESETN;
  logic          S00_AXI_arvalid, S01_AXI_arvalid;
  logic [3:0]    S00_AXI_arqos, S01_AXI_arqos;
  logic          M_AXI_arready, M_AXI_rvalid, M_AXI_rready, M_AXI_rlast;
  logic          ar_enable, ar_select, r_select, busy;
  logic [CW-1:0] outstanding;
  logic [CW+3:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  read_channel_scheduler #(.MAX_OUTSTANDING(MAX_OUT), .AGE_LIMIT(AGE_LIM)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S00_AXI_arvalid(S00_AXI_arvalid), .S00_AXI_arqos(S00_AXI_arqos),
    .S01_AXI_arvalid(S01_AXI_arvalid), .S01_AXI_arqos(S01_AXI_arqos),
    .M_AXI_arready(M_AXI_arready), .M_AXI_rvalid(M_AXI_rvalid),
    .M_AXI_rready(M_AXI_rready), .M_AXI_rlast(M_AXI_rlast),
    .ar_enable(ar_enable), .ar_select(ar_select), .r_select(r_select),
    .busy(busy), .outstanding(outstanding)
  );

  assign obs = {ar_enable, ar_select, r_select, busy, outstanding};

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [CW+3:0] pack(logic en, logic sel, logic bsy, int cnt);
    return {en, sel, sel, bsy, CW'(cnt)};
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic r_beat(input logic on);
    M_AXI_rvalid = on;
    M_AXI_rready = on;
    M_AXI_rlast  = on;
  endtask

  task automatic quiet();
    S00_AXI_arvalid = 1'b0; S00_AXI_arqos = 4'd0;
    S01_AXI_arvalid = 1'b0; S01_AXI_arqos = 4'd0;
    M_AXI_arready   = 1'b0;
    r_beat(1'b0);
  endtask

  task automatic apply_reset();
    quiet();
    ARESETN = 1'b0;
    tick(); tick();
    ARESETN = 1'b1;
    tick();
  endtask

  task automatic drain(input string tag);
    S00_AXI_arvalid = 1'b0;
    S01_AXI_arvalid = 1'b0;
    M_AXI_arready   = 1'b0;
    r_beat(1'b1);
    for (int i = 0; i < 32 && busy; i++) tick();
    r_beat(1'b0);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL %s_drain: busy=%b outstanding=%0d, required busy=0 within 32 cycles", tag, busy, outstanding);
    else n_pass++;
  endtask

  task automatic test_reset();
    quiet();
    ARESETN = 1'b0;
    S00_AXI_arvalid = 1'b1; S00_AXI_arqos = 4'd2;
    S01_AXI_arvalid = 1'b1; S01_AXI_arqos = 4'd5;
    tick(); tick();
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) $display("FAIL reset_outputs: got %b required %b", obs, pack(0, 0, 0, 0));
    else n_pass++;
    ARESETN = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(1, 1, 1, 0)) $display("FAIL qos_grant_m1: got %b required %b", obs, pack(1, 1, 1, 0));
    else n_pass++;
    drain("reset");
  endtask

  task automatic test_tie_release();
    apply_reset();
    S00_AXI_arvalid = 1'b1; S00_AXI_arqos = 4'd3;
    S01_AXI_arvalid = 1'b1; S01_AXI_arqos = 4'd3;
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 0)) $display("FAIL tie_grant_m0: got %b required %b", obs, pack(1, 0, 1, 0));
    else n_pass++;
    M_AXI_arready = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 1)) $display("FAIL single_ar_count: got %b required %b", obs, pack(1, 0, 1, 1));
    else n_pass++;
    S00_AXI_arvalid = 1'b0;
    M_AXI_arready   = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 1, 1)) $display("FAIL wait_data: got %b required %b", obs, pack(0, 0, 1, 1));
    else n_pass++;
    r_beat(1'b1);
    tick();
    r_beat(1'b0);
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) $display("FAIL release_bubble: got %b required %b", obs, pack(0, 0, 0, 0));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== pack(1, 1, 1, 0)) $display("FAIL next_owner_m1: got %b required %b", obs, pack(1, 1, 1, 0));
    else n_pass++;
    drain("tie");
  endtask

  task automatic test_max_outstanding();
    int rem  = 6;
    int hs_n = 0;
    logic hs;
    apply_reset();
    S00_AXI_arvalid = 1'b1; S00_AXI_arqos = 4'd7;
    tick();
    M_AXI_arready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      hs = ar_enable && (ar_select ? S01_AXI_arvalid : S00_AXI_arvalid) && M_AXI_arready;
      tick();
      if (hs) begin
        hs_n++;
        rem--;
        if (rem == 0) S00_AXI_arvalid = 1'b0;
      end
    end
    n_checks++;
    if (hs_n != MAX_OUT) $display("FAIL max_handshakes: got %0d required %0d", hs_n, MAX_OUT);
    else n_pass++;
    n_checks++;
    if (obs !== pack(0, 0, 1, MAX_OUT)) $display("FAIL max_full: got %b required %b", obs, pack(0, 0, 1, MAX_OUT));
    else n_pass++;
    r_beat(1'b1);
    tick();
    r_beat(1'b0);
    n_checks++;
    if (obs !== pack(1, 0, 1, MAX_OUT - 1)) $display("FAIL reenter_addr: got %b required %b", obs, pack(1, 0, 1, MAX_OUT - 1));
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 1, MAX_OUT)) $display("FAIL refill_full: got %b required %b", obs, pack(0, 0, 1, MAX_OUT));
    else n_pass++;
    drain("max");
  endtask

  task automatic test_overlap();
    apply_reset();
    S00_AXI_arvalid = 1'b1; S00_AXI_arqos = 4'd1;
    tick();
    M_AXI_arready = 1'b1;
    tick(); tick();
    r_beat(1'b1);
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 2)) $display("FAIL hs_rdone_at_2: got %b required %b", obs, pack(1, 0, 1, 2));
    else n_pass++;
    M_AXI_arready = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 1)) $display("FAIL rdone_alone: got %b required %b", obs, pack(1, 0, 1, 1));
    else n_pass++;
    M_AXI_arready = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(1, 0, 1, 1)) $display("FAIL hs_rdone_at_1: got %b required %b", obs, pack(1, 0, 1, 1));
    else n_pass++;
    drain("overlap");
    quiet();
    r_beat(1'b1);
    tick(); tick();
    r_beat(1'b0);
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) $display("FAIL spurious_rlast: got %b required %b", obs, pack(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_async_reset();
    apply_reset();
    S01_AXI_arvalid = 1'b1; S01_AXI_arqos = 4'd9;
    tick();
    M_AXI_arready = 1'b1;
    tick(); tick(); tick();
    S01_AXI_arvalid = 1'b0;
    M_AXI_arready   = 1'b0;
    tick();
    n_checks++;
    if (obs !== pack(0, 1, 1, 3)) $display("FAIL data_count_3: got %b required %b", obs, pack(0, 1, 1, 3));
    else n_pass++;
    #2;
    ARESETN = 1'b0;
    #1;
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) $display("FAIL async_reset: got %b required %b", obs, pack(0, 0, 0, 0));
    else n_pass++;
    @(posedge ACLK);
    #1;
    ARESETN = 1'b1;
    tick();
    n_checks++;
    if (obs !== pack(0, 0, 0, 0)) $display("FAIL post_reset_idle: got %b required %b", obs, pack(0, 0, 0, 0));
    else n_pass++;
  endtask

  task automatic test_aging_fairness();
    int   cnt_m    = 0;
    int   m0_hs    = 0;
    logic m1_owned = 1'b0;
    logic hs, done, sel;
    apply_reset();
    S00_AXI_arvalid = 1'b1; S00_AXI_arqos = 4'd15;
    S01_AXI_arvalid = 1'b1; S01_AXI_arqos = 4'd0;
    M_AXI_arready   = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      sel  = ar_select;
      hs   = ar_enable && (sel ? S01_AXI_arvalid : S00_AXI_arvalid) && M_AXI_arready;
      done = (cnt_m > 0) && (cyc % 2 == 1);
      r_beat(done);
      if (busy && sel) m1_owned = 1'b1;
      tick();
      if (hs && !done)      cnt_m++;
      else if (done && !hs) cnt_m--;
      if (hs && !sel) m0_hs++;
    end
    if (busy && ar_select) m1_owned = 1'b1;
`ifdef READ_SCHED_AGING_EN
    n_checks++;
    if (m1_owned !== 1'b1) $display("FAIL aged_m1_served: m1_owned=%b required 1", m1_owned);
    else n_pass++;
`else
    n_checks++;
    if (m1_owned !== 1'b0) $display("FAIL m0_keeps_path: m1_owned=%b required 0", m1_owned);
    else n_pass++;
    n_checks++;
    if (m0_hs <= 20) $display("FAIL m0_streaming: m0 handshakes=%0d required >20", m0_hs);
    else n_pass++;
`endif
    drain("aging");
  endtask

  task automatic test_random();
    int   exp_cnt = 0;
    logic hs, done, sel, was_idle, any_v, exp_owner, prev_busy, prev_sel;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!S00_AXI_arvalid && $urandom_range(0, 2) == 0) begin
        S00_AXI_arvalid = 1'b1;
        S00_AXI_arqos   = 4'($urandom_range(0, 15));
      end
      if (!S01_AXI_arvalid && $urandom_range(0, 2) == 0) begin
        S01_AXI_arvalid = 1'b1;
        S01_AXI_arqos   = 4'($urandom_range(0, 15));
      end
      M_AXI_arready = 1'($urandom_range(0, 1));
      M_AXI_rvalid  = (exp_cnt > 0) && ($urandom_range(0, 1) == 1);
      M_AXI_rready  = 1'($urandom_range(0, 1));
      M_AXI_rlast   = 1'($urandom_range(0, 1));
      sel       = ar_select;
      hs        = ar_enable && (sel ? S01_AXI_arvalid : S00_AXI_arvalid) && M_AXI_arready;
      done      = M_AXI_rvalid && M_AXI_rready && M_AXI_rlast;
      was_idle  = !busy;
      any_v     = S00_AXI_arvalid || S01_AXI_arvalid;
      exp_owner = S01_AXI_arvalid && (!S00_AXI_arvalid || (S01_AXI_arqos > S00_AXI_arqos));
      prev_busy = busy;
      prev_sel  = ar_select;
      tick();
      if (hs && !done)      exp_cnt++;
      else if (done && !hs) exp_cnt--;
      n_checks++;
      if (outstanding !== CW'(exp_cnt)) $display("FAIL rand_count cyc %0d: got %0d required %0d", cyc, outstanding, exp_cnt);
      else n_pass++;
      n_checks++;
      if (r_select !== ar_select) $display("FAIL rand_rsel cyc %0d: r_select=%b required %b", cyc, r_select, ar_select);
      else n_pass++;
      n_checks++;
      if (ar_enable && (outstanding >= CW'(MAX_OUT))) $display("FAIL rand_cap cyc %0d: ar_enable=1 at outstanding %0d required <%0d", cyc, outstanding, MAX_OUT);
      else n_pass++;
      if (prev_busy && busy) begin
        n_checks++;
        if (ar_select !== prev_sel) $display("FAIL rand_owner_hold cyc %0d: got %b required %b", cyc, ar_select, prev_sel);
        else n_pass++;
      end
`ifndef READ_SCHED_AGING_EN
      if (was_idle) begin
        n_checks++;
        if (busy !== any_v) $display("FAIL rand_grant cyc %0d: busy=%b required %b", cyc, busy, any_v);
        else n_pass++;
        if (any_v) begin
          n_checks++;
          if (ar_select !== exp_owner) $display("FAIL rand_arb cyc %0d: owner=%b required %b", cyc, ar_select, exp_owner);
          else n_pass++;
        end
      end
`endif
      if (hs) begin
        if (sel) S01_AXI_arvalid = 1'($urandom_range(0, 1));
        else     S00_AXI_arvalid = 1'($urandom_range(0, 1));
      end
    end
    drain("random");
  endtask

  initial begin
    ARESETN = 1'b0;
    quiet();
    test_reset();
    test_tie_release();
    test_max_outstanding();
    test_overlap();
    test_async_reset();
    test_aging_fairness();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
